vending_machine: RTL and testbench

Coin-accepting vending controller for a single product priced at 15 units. It accepts 5- and 10-unit coins one per clock, accumulates credit, dispenses when credit reaches 15, and returns any overpayment. A cancel code refunds held credit. It is a leaf block driven directly by the coin-acceptor interface and feeds the dispense and change-return actuators.

---
 rtl/vending_pkg.sv | 58 +++++
 rtl/vending_machine.sv | 73 +++++++
 tb/tb_vending_machine.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vending_pkg.sv
// vending_pkg
// Shared types and constants for the single-product vending controller.
// Credit is tracked in units of 5; the product costs PRICE units.
package vending_pkg;

    // Credit held between edges. 2'b11 is unreachable and recovers to S0.
    typedef enum logic [1:0] {
        S0  = 2'b00,
        S5  = 2'b01,
        S10 = 2'b10
    } state_t;

    // Coin-acceptor codes on the input.
    localparam logic [1:0] COIN_NONE   = 2'b00;
    localparam logic [1:0] COIN_5      = 2'b01;
    localparam logic [1:0] COIN_10     = 2'b10;
    localparam logic [1:0] COIN_CANCEL = 2'b11;

    // Change/refund actuator codes.
    localparam logic [1:0] CHG_NONE = 2'b00;
    localparam logic [1:0] CHG_5    = 2'b01;
    localparam logic [1:0] CHG_10   = 2'b10;

    localparam logic [4:0] PRICE = 5'd15;

    function automatic logic [4:0] coin_units(input logic [1:0] code);
        case (code)
            COIN_5:  coin_units = 5'd5;
            COIN_10: coin_units = 5'd10;
            default: coin_units = 5'd0;
        endcase
    endfunction

    function automatic logic [4:0] state_credit(input state_t s);
        case (s)
            S5:      state_credit = 5'd5;
            S10:     state_credit = 5'd10;
            default: state_credit = 5'd0;
        endcase
    endfunction

    function automatic state_t credit_state(input logic [4:0] credit);
        case (credit)
            5'd5:    credit_state = S5;
            5'd10:   credit_state = S10;
            default: credit_state = S0;
        endcase
    endfunction

    function automatic logic [1:0] change_code(input logic [4:0] units);
        case (units)
            5'd5:    change_code = CHG_5;
            5'd10:   change_code = CHG_10;
            default: change_code = CHG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/vending_machine.sv
// vending_machine
// Accepts one 5- or 10-unit coin per clock, vends when credit reaches
// PRICE, returns overpayment, and refunds held credit on cancel.
// Ports:
//   clk    - system clock, rising edge
//   rst    - synchronous active-low reset
//   in     - coin code: 00 none, 01 five, 10 ten, 11 cancel
//   out    - registered one-cycle dispense pulse
//   change - registered one-cycle change/refund code: 00 none, 01 five, 10 ten
//
// state | meaning
// S0    | no credit held
// S5    | 5 units held
// S10   | 10 units held
module vending_machine
    import vending_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] in,
    output logic       out,
    output logic [1:0] change
);

    state_t     r_state;
    logic       r_out;
    logic [1:0] r_change;

    state_t     w_state_nxt;
    logic       w_out_nxt;
    logic [1:0] w_change_nxt;
    logic [4:0] w_credit;
    logic [4:0] w_sum;
    logic       w_state_valid;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S0;
            r_out    <= 1'b0;
            r_change <= CHG_NONE;
        end else begin
            r_state  <= w_state_nxt;
            r_out    <= w_out_nxt;
            r_change <= w_change_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = S0;
        w_out_nxt     = 1'b0;
        w_change_nxt  = CHG_NONE;
        w_credit      = state_credit(r_state);
        w_sum         = w_credit + coin_units(in);
        w_state_valid = (r_state == S0) || (r_state == S5) || (r_state == S10);

        // An invalid encoding falls through to the S0/no-output defaults.
        if (w_state_valid) begin
            if (in == COIN_CANCEL) begin
                w_change_nxt = change_code(w_credit);
            end else if (w_sum >= PRICE) begin
                // Credit never exceeds 10 before a coin, so the excess is 0 or 5.
                w_out_nxt    = 1'b1;
                w_change_nxt = change_code(w_sum - PRICE);
            end else begin
                w_state_nxt = credit_state(w_sum);
            end
        end
    end

    assign out    = r_out;
    assign change = r_change;

endmodule

// File: tb/tb_vending_machine.sv
module tb_vending_machine;

    logic       clk;
    logic       rst;
    logic [1:0] in;
    logic       out;
    logic [1:0] change;

    int n_checks = 0;
    int n_fail   = 0;

    vending_machine dut (
        .clk    (clk),
        .rst    (rst),
        .in     (in),
        .out    (out),
        .change (change)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive on the falling edge, then sample 1 time unit after the rising edge.
    task automatic apply(input logic rst_v, input logic [1:0] coin);
        @(negedge clk);
        rst = rst_v;
        in  = coin;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply(1'b0, 2'b10);
        n_checks++;
        if ({out, change} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_edge1: got out=%b change=%b want out=0 change=00", out, change);
        end
        apply(1'b0, 2'b10);
        n_checks++;
        if ({out, change} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_edge2: got out=%b change=%b want out=0 change=00", out, change);
        end
        // If reset had let the 10-coins through, 01 here would vend.
        apply(1'b1, 2'b01);
        n_checks++;
        if ({out, change} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_release_first: got out=%b change=%b want out=0 change=00", out, change);
        end
        apply(1'b1, 2'b10);
        n_checks++;
        if ({out, change} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_release_vend: got out=%b change=%b want out=1 change=00", out, change);
        end
    endtask

    task automatic test_exact_pay();
        apply(1'b1, 2'b01);
        apply(1'b1, 2'b01);
        n_checks++;
        if ({out, change} !== 3'b000) begin
            n_fail++;
            $display("FAIL exact_pay_partial: got out=%b change=%b want out=0 change=00", out, change);
        end
        apply(1'b1, 2'b01);
        n_checks++;
        if ({out, change} !== 3'b100) begin
            n_fail++;
            $display("FAIL exact_pay_vend: got out=%b change=%b want out=1 change=00", out, change);
        end
        apply(1'b1, 2'b00);
        n_checks++;
        if ({out, change} !== 3'b000) begin
            n_fail++;
            $display("FAIL exact_pay_pulse_end: got out=%b change=%b want out=0 change=00", out, change);
        end
    endtask

    task automatic test_overpay();
        apply(1'b1, 2'b10);
        apply(1'b1, 2'b10);
        n_checks++;
        if ({out, change} !== 3'b101) begin
            n_fail++;
            $display("FAIL overpay_vend1: got out=%b change=%b want out=1 change=01", out, change);
        end
        apply(1'b1, 2'b10);
        n_checks++;
        if ({out, change} !== 3'b000) begin
            n_fail++;
            $display("FAIL overpay_restart: got out=%b change=%b want out=0 change=00", out, change);
        end
        apply(1'b1, 2'b10);
        n_checks++;
        if ({out, change} !== 3'b101) begin
            n_fail++;
            $display("FAIL overpay_vend2: got out=%b change=%b want out=1 change=01", out, change);
        end
    endtask

    task automatic test_mixed();
        apply(1'b1, 2'b10);
        apply(1'b1, 2'b01);
        n_checks++;
        if ({out, change} !== 3'b100) begin
            n_fail++;
            $display("FAIL mixed_10_5: got out=%b change=%b want out=1 change=00", out, change);
        end
        apply(1'b1, 2'b01);
        apply(1'b1, 2'b10);
        n_checks++;
        if ({out, change} !== 3'b100) begin
            n_fail++;
            $display("FAIL mixed_5_10: got out=%b change=%b want out=1 change=00", out, change);
        end
    endtask

    task automatic test_cancel();
        apply(1'b1, 2'b01);
        apply(1'b1, 2'b11);
        n_checks++;
        if ({out, change} !== 3'b001) begin
            n_fail++;
            $display("FAIL cancel_5: got out=%b change=%b want out=0 change=01", out, change);
        end
        apply(1'b1, 2'b10);
        apply(1'b1, 2'b11);
        n_checks++;
        if ({out, change} !== 3'b010) begin
            n_fail++;
            $display("FAIL cancel_10: got out=%b change=%b want out=0 change=10", out, change);
        end
        apply(1'b1, 2'b11);
        n_checks++;
        if ({out, change} !== 3'b000) begin
            n_fail++;
            $display("FAIL cancel_empty: got out=%b change=%b want out=0 change=00", out, change);
        end
    endtask

    task automatic test_midreset_idle();
        apply(1'b1, 2'b10);
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 2'b00);
            n_checks++;
            if ({out, change} !== 3'b000) begin
                n_fail++;
                $display("FAIL idle_hold_%0d: got out=%b change=%b want out=0 change=00", i, out, change);
            end
        end
        apply(1'b0, 2'b00);
        n_checks++;
        if ({out, change} !== 3'b000) begin
            n_fail++;
            $display("FAIL midreset_no_refund: got out=%b change=%b want out=0 change=00", out, change);
        end
        apply(1'b1, 2'b01);
        n_checks++;
        if ({out, change} !== 3'b000) begin
            n_fail++;
            $display("FAIL midreset_credit_cleared: got out=%b change=%b want out=0 change=00", out, change);
        end
        apply(1'b1, 2'b10);
        n_checks++;
        if ({out, change} !== 3'b100) begin
            n_fail++;
            $display("FAIL midreset_vend: got out=%b change=%b want out=1 change=00", out, change);
        end
    endtask

    // Random coins and occasional resets against a credit-counting model.
    task automatic test_random();
        int         credit = 0;   // block is idle after the directed tests
        logic       exp_out = 1'b0;
        logic [1:0] exp_chg = 2'b00;
        logic       prev_out;
        logic [1:0] prev_chg;
        logic       r_v;
        logic [1:0] coin;
        int         units;
        for (int i = 0; i < 400; i++) begin
            prev_out = out;
            prev_chg = change;
            r_v  = ($urandom_range(0, 19) != 0);
            coin = 2'($urandom_range(0, 3));
            @(negedge clk);
            rst = r_v;
            in  = coin;
            #1;
            // Outputs must not follow the input between edges.
            n_checks++;
            if ({out, change} !== {prev_out, prev_chg}) begin
                n_fail++;
                $display("FAIL rand_no_comb_path[%0d]: got out=%b change=%b want out=%b change=%b",
                         i, out, change, prev_out, prev_chg);
            end
            @(posedge clk);
            #1;
            exp_out = 1'b0;
            exp_chg = 2'b00;
            if (!r_v) begin
                credit = 0;
            end else if (coin == 2'b11) begin
                exp_chg = 2'(credit / 5);
                credit  = 0;
            end else begin
                units  = (coin == 2'b01) ? 5 : (coin == 2'b10) ? 10 : 0;
                credit = credit + units;
                if (credit >= 15) begin
                    exp_out = 1'b1;
                    exp_chg = 2'((credit - 15) / 5);
                    credit  = 0;
                end
            end
            n_checks++;
            if ({out, change} !== {exp_out, exp_chg}) begin
                n_fail++;
                $display("FAIL rand_step[%0d] rst=%b in=%b: got out=%b change=%b want out=%b change=%b",
                         i, r_v, coin, out, change, exp_out, exp_chg);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        in  = 2'b00;
        test_reset();
        test_exact_pay();
        test_overpay();
        test_mixed();
        test_cancel();
        test_midreset_idle();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
